// File: rtl/rooth_clint_mc.sv
// Core-local interrupt controller: takes sync traps (ECALL/EBREAK), masked async
// interrupts and MRET, and sequences the mepc/mstatus/mcause writes and PC redirect.
module rooth_clint_mc #(
    parameter int                 INT_NUM    = 8,
    parameter logic [INT_NUM-1:0] INT_EDGE   = {INT_NUM{1'b0}},
    parameter int                 CAUSE_BASE = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INT_NUM-1:0] int_flag_i,
    input  logic [INT_NUM-1:0] int_en_i,
    input  logic [31:0]        wb_inst_i,
    input  logic [31:0]        wb_inst_addr_i,
    input  logic [31:0]        int_epc_i,
    input  logic [31:0]        csr_mtvec,
    input  logic [31:0]        csr_mepc,
    input  logic [31:0]        csr_mstatus,
    output logic               we_o,
    output logic [11:0]        waddr_o,
    output logic [31:0]        data_o,
    output logic               hold_flag_o,
    output logic               int_assert_o,
    output logic [31:0]        int_addr_o,
    output logic [INT_NUM-1:0] int_ack_o,
    output logic [2:0]         dbg_state
);

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    typedef enum logic [2:0] {
        S_IDLE, S_MEPC, S_MSTATUS, S_MCAUSE, S_ASSERT, S_MRET_MSTATUS, S_MRET_ASSERT
    } state_t;

    state_t             state_q, state_d;
    logic [INT_NUM-1:0] flag_q, pend_q, pending, eligible, win_onehot;
    logic [4:0]         winner;
    logic [31:0]        epc_q, cause_q, cause_d;
    logic               is_ecall, is_ebreak, is_sync, is_mret, async_req, sel_trap;

    // Edge sources use the latched bit, level sources pass the raw request through.
    assign pending   = (INT_EDGE & pend_q) | (~INT_EDGE & int_flag_i);
    assign eligible  = pending & int_en_i;
    assign async_req = (|eligible) & csr_mstatus[3];

    assign is_ecall  = (wb_inst_i == INST_ECALL);
    assign is_ebreak = (wb_inst_i == INST_EBREAK);
    assign is_sync   = is_ecall | is_ebreak;
    assign is_mret   = (wb_inst_i == INST_MRET);
    assign sel_trap  = is_sync | async_req;

    always_comb begin
        winner = '0;
        for (int i = INT_NUM - 1; i >= 0; i--) begin
            if (eligible[i]) winner = 5'(i);
        end
        win_onehot = INT_NUM'(1) << winner;
    end

    always_comb begin
        if (is_ecall)       cause_d = 32'd11;
        else if (is_ebreak) cause_d = 32'd3;
        else                cause_d = 32'h8000_0000 | (32'(CAUSE_BASE) + 32'(winner));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            flag_q  <= '0;
            pend_q  <= '0;
            epc_q   <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            flag_q  <= int_flag_i;
            // A new rising edge beats the ack clear in the same cycle.
            pend_q  <= INT_EDGE & ((int_flag_i & ~flag_q) | (pend_q & ~int_ack_o));
            if (state_q == S_IDLE && sel_trap) begin
                epc_q   <= is_sync ? wb_inst_addr_i : int_epc_i;
                cause_q <= cause_d;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        int_ack_o = '0;
        case (state_q)
            S_IDLE: begin
                if (sel_trap) begin
                    state_d = S_MEPC;
                    if (!is_sync) int_ack_o = win_onehot;
                end else if (is_mret) begin
                    state_d = S_MRET_MSTATUS;
                end
            end
            S_MEPC:         state_d = S_MSTATUS;
            S_MSTATUS:      state_d = S_MCAUSE;
            S_MCAUSE:       state_d = S_ASSERT;
            S_ASSERT:       state_d = S_IDLE;
            S_MRET_MSTATUS: state_d = S_MRET_ASSERT;
            S_MRET_ASSERT:  state_d = S_IDLE;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        we_o         = 1'b0;
        waddr_o      = '0;
        data_o       = '0;
        int_assert_o = 1'b0;
        int_addr_o   = '0;
        hold_flag_o  = (state_q != S_IDLE) || sel_trap || is_mret;
        case (state_q)
            S_MEPC: begin
                we_o    = 1'b1;
                waddr_o = 12'h341;
                data_o  = epc_q;
            end
            S_MSTATUS: begin
                we_o      = 1'b1;
                waddr_o   = 12'h300;
                data_o    = csr_mstatus;
                data_o[7] = csr_mstatus[3];
                data_o[3] = 1'b0;
            end
            S_MCAUSE: begin
                we_o    = 1'b1;
                waddr_o = 12'h342;
                data_o  = cause_q;
            end
            S_ASSERT: begin
                int_assert_o = 1'b1;
                // Vectored mode only applies to interrupts; exceptions go to the base.
                if (cause_q[31] && csr_mtvec[1:0] == 2'b01)
                    int_addr_o = {csr_mtvec[31:2], 2'b00} + (cause_q << 2);
                else
                    int_addr_o = {csr_mtvec[31:2], 2'b00};
            end
            S_MRET_MSTATUS: begin
                we_o      = 1'b1;
                waddr_o   = 12'h300;
                data_o    = csr_mstatus;
                data_o[3] = csr_mstatus[7];
                data_o[7] = 1'b1;
            end
            S_MRET_ASSERT: begin
                int_assert_o = 1'b1;
                int_addr_o   = csr_mepc;
            end
            default: ;
        endcase
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_rooth_clint_mc.sv
// Directed bench for rooth_clint_mc: a table of trap scenarios plus hand-written
// sequences for MRET, masking, edge latching and mid-sequence reset.
module tb_rooth_clint_mc;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  int_flag, int_en;
    logic [31:0] wb_inst, wb_inst_addr, int_epc, csr_mtvec, csr_mepc, csr_mstatus;
    logic        we, hold_flag, int_assert;
    logic [11:0] waddr;
    logic [31:0] data, int_addr;
    logic [7:0]  int_ack;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    rooth_clint_mc #(.INT_NUM(8), .INT_EDGE(8'h08), .CAUSE_BASE(16)) dut (
        .clk(clk), .rst(rst), .int_flag_i(int_flag), .int_en_i(int_en),
        .wb_inst_i(wb_inst), .wb_inst_addr_i(wb_inst_addr), .int_epc_i(int_epc),
        .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc), .csr_mstatus(csr_mstatus),
        .we_o(we), .waddr_o(waddr), .data_o(data), .hold_flag_o(hold_flag),
        .int_assert_o(int_assert), .int_addr_o(int_addr), .int_ack_o(int_ack),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst, iaddr;
        logic [7:0]  flags, en;
        logic [31:0] mst, mtvec, epc_in;
        logic [7:0]  exp_ack;
        logic [31:0] exp_epc, exp_mst, exp_cause, exp_addr;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Entered at a negedge in IDLE with the triggering inputs already applied;
    // returns #1 after the negedge of the cycle back in IDLE.
    task automatic run_trap(input logic [7:0] exp_ack, input logic [31:0] epc,
                            input logic [31:0] mst, input logic [31:0] cause,
                            input logic [31:0] addr, input logic [7:0] mid_flags);
        #1;
        chk("detect_hold", hold_flag, 1);
        chk("detect_ack", int_ack, exp_ack);
        chk("detect_we", we, 0);
        @(negedge clk); wb_inst = NOP; int_flag = mid_flags; #1;
        chk("mepc_we", we, 1);
        chk("mepc_waddr", waddr, 12'h341);
        chk("mepc_data", data, epc);
        chk("mepc_ack", int_ack, 0);
        @(negedge clk); int_flag = 8'h00; #1;
        chk("mstatus_waddr", waddr, 12'h300);
        chk("mstatus_data", data, mst);
        @(negedge clk); #1;
        chk("mcause_waddr", waddr, 12'h342);
        chk("mcause_data", data, cause);
        @(negedge clk); #1;
        chk("assert_we", we, 0);
        chk("assert_flag", int_assert, 1);
        chk("assert_addr", int_addr, addr);
        chk("assert_hold", hold_flag, 1);
        @(negedge clk); #1;
    endtask

    initial begin
        //          inst    iaddr        flags  en     mst        mtvec         epc_in        ack    epc          mst        cause         addr
        vecs[0] = '{ECALL,  32'h100,     8'h00, 8'h00, 32'h08,    32'h200,      32'hDEAD0000, 8'h00, 32'h100,     32'h80,    32'd11,       32'h200};
        vecs[1] = '{EBREAK, 32'h44,      8'h00, 8'h00, 32'h00,    32'h301,      32'hDEAD0000, 8'h00, 32'h44,      32'h00,    32'd3,        32'h300};
        vecs[2] = '{NOP,    32'h0,       8'h24, 8'hFF, 32'h08,    32'h200,      32'h500,      8'h04, 32'h500,     32'h80,    32'h80000012, 32'h200};
        vecs[3] = '{NOP,    32'h0,       8'h01, 8'hFF, 32'h88,    32'h201,      32'h600,      8'h01, 32'h600,     32'h80,    32'h80000010, 32'h240};
        vecs[4] = '{ECALL,  32'h2000,    8'h02, 8'hFF, 32'h1888,  32'hFFFFFFF1, 32'h700,      8'h00, 32'h2000,    32'h1880,  32'd11,       32'hFFFFFFF0};
        vecs[5] = '{NOP,    32'h0,       8'h80, 8'h80, 32'h08,    32'hFFFFFFF1, 32'h800,      8'h80, 32'h800,     32'h80,    32'h80000017, 32'h4C};
        vecs[6] = '{NOP,    32'h0,       8'h06, 8'h04, 32'h0F,    32'h200,      32'h900,      8'h04, 32'h900,     32'h87,    32'h80000012, 32'h200};

        rst = 1'b1; int_flag = 8'h00; int_en = 8'h00; wb_inst = NOP; wb_inst_addr = '0;
        int_epc = '0; csr_mtvec = '0; csr_mepc = '0; csr_mstatus = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_we", we, 0);
        chk("reset_hold", hold_flag, 0);
        chk("reset_assert", int_assert, 0);
        chk("reset_ack", int_ack, 0);
        chk("reset_addr", int_addr, 0);
        chk("reset_data", data, 0);
        @(negedge clk); rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            wb_inst = vecs[v].inst; wb_inst_addr = vecs[v].iaddr; int_flag = vecs[v].flags;
            int_en = vecs[v].en; csr_mstatus = vecs[v].mst; csr_mtvec = vecs[v].mtvec;
            int_epc = vecs[v].epc_in;
            run_trap(vecs[v].exp_ack, vecs[v].exp_epc, vecs[v].exp_mst,
                     vecs[v].exp_cause, vecs[v].exp_addr, 8'h00);
            chk("idle_hold", hold_flag, 0);
            chk("idle_assert", int_assert, 0);
        end

        // MRET restores MIE from MPIE and jumps to mepc.
        @(negedge clk); wb_inst = MRET; csr_mstatus = 32'h80; csr_mepc = 32'h104; int_en = 8'hFF; #1;
        chk("mret_detect_hold", hold_flag, 1);
        chk("mret_detect_ack", int_ack, 0);
        @(negedge clk); wb_inst = NOP; #1;
        chk("mret_we", we, 1);
        chk("mret_waddr", waddr, 12'h300);
        chk("mret_data", data, 32'h88);
        @(negedge clk); #1;
        chk("mret_assert", int_assert, 1);
        chk("mret_addr", int_addr, 32'h104);
        chk("mret_assert_we", we, 0);
        @(negedge clk); #1;
        chk("mret_idle_hold", hold_flag, 0);

        @(negedge clk); wb_inst = MRET; csr_mstatus = 32'h1808; #1;
        @(negedge clk); wb_inst = NOP; #1;
        chk("mret2_data", data, 32'h1880);
        @(negedge clk); @(negedge clk); #1;

        // Async request outranks MRET in the same cycle.
        @(negedge clk); wb_inst = MRET; int_flag = 8'h01; csr_mstatus = 32'h08;
        csr_mtvec = 32'h200; int_epc = 32'hB00;
        run_trap(8'h01, 32'hB00, 32'h80, 32'h80000010, 32'h200, 8'h00);
        chk("prio_idle_hold", hold_flag, 0);

        // Global MIE clear blocks an enabled level source.
        @(negedge clk); int_flag = 8'h01; int_en = 8'hFF; csr_mstatus = 32'h00; #1;
        chk("mie0_hold", hold_flag, 0);
        chk("mie0_ack", int_ack, 0);
        @(negedge clk); #1;
        chk("mie0_we", we, 0);
        int_flag = 8'h00;

        // Edge source 3 pulses while disabled; pending survives until enabled.
        @(negedge clk); int_en = 8'h00; csr_mstatus = 32'h08; csr_mtvec = 32'h200;
        int_epc = 32'hA00; int_flag = 8'h08;
        @(negedge clk); int_flag = 8'h00; #1;
        chk("edge_masked_hold", hold_flag, 0);
        repeat (3) @(negedge clk);
        #1;
        chk("edge_still_masked", int_ack, 0);
        @(negedge clk); int_en = 8'h08;
        // A second pulse lands mid-sequence and must be served after returning to IDLE.
        run_trap(8'h08, 32'hA00, 32'h80, 32'h80000013, 32'h200, 8'h08);
        run_trap(8'h08, 32'hA00, 32'h80, 32'h80000013, 32'h200, 8'h00);
        chk("edge_cleared_hold", hold_flag, 0);
        chk("edge_cleared_ack", int_ack, 0);

        // Reset during the mstatus write aborts the sequence.
        @(negedge clk); int_en = 8'h00; wb_inst = ECALL; wb_inst_addr = 32'h300; #1;
        chk("rstmid_detect", hold_flag, 1);
        @(negedge clk); wb_inst = NOP;
        @(negedge clk); #1;
        chk("rstmid_mstatus", waddr, 12'h300);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("rstmid_we", we, 0);
        chk("rstmid_hold", hold_flag, 0);
        chk("rstmid_assert", int_assert, 0);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("rstmid_no_mcause_we", we, 0);
        chk("rstmid_no_mcause_addr", waddr, 0);
        @(negedge clk); #1;
        chk("rstmid_no_assert", int_assert, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
